// File: rtl/head_table.sv
// head_table: per-bucket head-pointer table for a hashed linked-list store.
// Each entry holds {ptr_val, ptr}. After reset or a clear pulse, an INIT
// walk zeroes every entry (one per cycle). After that the table is READY and
// accepts one user write and one pipelined read per cycle.
//
// Ports
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   wr_addr_i/wr_data_*   : write address and {ptr_val, ptr} to store
//   wr_en_i               : write strobe (ignored while initialising)
//   rd_addr_i, rd_en_i    : read request (ignored while initialising)
//   clear_i               : one-cycle pulse that restarts initialisation
//   rd_data_ptr_o/_val_o  : read result, held while rd_valid_o is low
//   rd_valid_o            : one-cycle qualifier, two cycles after rd_en_i
//   init_done_o           : table cleared and operational
//   o_dbg_state           : current FSM state (0 = INIT, 1 = READY)
//
// Handshake: there is no back-pressure. A read sampled on edge N is valid
// in the cycle after edge N+2. It sees every write sampled at or before
// edge N and no write sampled later.

package head_table_pkg;
    localparam int BUCKET_WIDTH   = 4;
    localparam int HEAD_PTR_WIDTH = 8;
endpackage

module head_table #(
    parameter int A_WIDTH = head_table_pkg::BUCKET_WIDTH,
    parameter int D_WIDTH = head_table_pkg::HEAD_PTR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] wr_addr_i,
    input  logic [D_WIDTH-1:0] wr_data_ptr_i,
    input  logic               wr_data_ptr_val_i,
    input  logic               wr_en_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    input  logic               rd_en_i,
    input  logic               clear_i,
    output logic [D_WIDTH-1:0] rd_data_ptr_o,
    output logic               rd_data_ptr_val_o,
    output logic               rd_valid_o,
    output logic               init_done_o,
    output logic               o_dbg_state
);

    localparam int DEPTH = 1 << A_WIDTH;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [A_WIDTH-1:0] r_cnt;
    logic [A_WIDTH-1:0] w_cnt_nxt;
    logic               r_init_done;

    logic               w_mem_we;
    logic [A_WIDTH-1:0] w_mem_waddr;
    logic [D_WIDTH:0]   w_mem_wdata;
    logic               w_user_wr;
    logic               w_rd_accept;

    logic [D_WIDTH:0]   r_mem [DEPTH];
    logic [D_WIDTH:0]   r_ram_q;

    logic               r_rd_v1;
    logic               r_byp;
    logic [D_WIDTH:0]   r_byp_data;
    logic               r_rd_v2;
    logic [D_WIDTH:0]   r_rd_d2;
    logic               r_rd_valid;
    logic [D_WIDTH:0]   r_rd_data;

    // Next-state logic and the single RAM write port. INIT owns the write
    // port; in READY a clear pulse wins over a same-cycle user write.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_cnt;
        w_mem_wdata = '0;
        w_user_wr   = 1'b0;
        case (r_state)
            INIT: begin
                w_mem_we = 1'b1;
                if (clear_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == '1) begin
                    // Last entry is written on this edge; counter holds.
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt + A_WIDTH'(1);
                end
            end
            READY: begin
                if (clear_i) begin
                    w_state_nxt = INIT;
                    w_cnt_nxt   = '0;
                end else if (wr_en_i) begin
                    w_user_wr   = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_waddr = wr_addr_i;
                    w_mem_wdata = {wr_data_ptr_val_i, wr_data_ptr_i};
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= (w_state_nxt == READY);
        end
    end

    // Simple dual-port RAM, read-before-write; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        r_ram_q <= r_mem[rd_addr_i];
    end

    assign w_rd_accept = rd_en_i && (r_state == READY);

    // Read pipeline: stage 1 captures RAM data plus a write-first bypass for
    // a same-edge write to the read address (the RAM returns old data then);
    // stage 2 resolves the bypass; stage 3 is the held output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_v1    <= 1'b0;
            r_byp      <= 1'b0;
            r_byp_data <= '0;
            r_rd_v2    <= 1'b0;
            r_rd_d2    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= w_rd_accept;
            r_byp      <= w_user_wr && (wr_addr_i == rd_addr_i);
            r_byp_data <= {wr_data_ptr_val_i, wr_data_ptr_i};
            r_rd_v2    <= r_rd_v1;
            r_rd_d2    <= r_byp ? r_byp_data : r_ram_q;
            r_rd_valid <= r_rd_v2;
            if (r_rd_v2) begin
                r_rd_data <= r_rd_d2;
            end
        end
    end

    assign rd_valid_o        = r_rd_valid;
    assign rd_data_ptr_val_o = r_rd_data[D_WIDTH];
    assign rd_data_ptr_o     = r_rd_data[D_WIDTH-1:0];
    assign init_done_o       = r_init_done;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_head_table.sv
module tb_head_table;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] wr_addr_i = '0;
    logic [DW-1:0] wr_data_ptr_i = '0;
    logic          wr_data_ptr_val_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic          rd_en_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] rd_data_ptr_o;
    logic          rd_data_ptr_val_o;
    logic          rd_valid_o;
    logic          init_done_o;
    logic          o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_ptr [16];
    logic          exp_val [16];

    head_table #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .wr_addr_i         (wr_addr_i),
        .wr_data_ptr_i     (wr_data_ptr_i),
        .wr_data_ptr_val_i (wr_data_ptr_val_i),
        .wr_en_i           (wr_en_i),
        .rd_addr_i         (rd_addr_i),
        .rd_en_i           (rd_en_i),
        .clear_i           (clear_i),
        .rd_data_ptr_o     (rd_data_ptr_o),
        .rd_data_ptr_val_o (rd_data_ptr_val_o),
        .rd_valid_o        (rd_valid_o),
        .init_done_o       (init_done_o),
        .o_dbg_state       (o_dbg_state)
    );

    // clock block
    always #5 clk_i = ~clk_i;

    // driver tasks: inputs change and outputs are sampled 1 ns after posedge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [DW-1:0] ptr, input logic val);
        wr_addr_i         = addr[AW-1:0];
        wr_data_ptr_i     = ptr;
        wr_data_ptr_val_i = val;
        wr_en_i           = 1'b1;
        tick();
        wr_en_i           = 1'b0;
    endtask

    task automatic read_entry(input int addr, output logic v, output logic pv, output logic [DW-1:0] p);
        rd_addr_i = addr[AW-1:0];
        rd_en_i   = 1'b1;
        tick();
        rd_en_i   = 1'b0;
        tick();
        tick();
        v  = rd_valid_o;
        pv = rd_data_ptr_val_o;
        p  = rd_data_ptr_o;
    endtask

    task automatic count_init_edges(input string name);
        int edges;
        edges = 41;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (init_done_o) begin
                edges = k;
                break;
            end
        end
        n_cmp++;
        if (edges !== 16) begin
            n_err++;
            $display("FAIL %s: init_done after %0d edges, expected 16", name, edges);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if ({init_done_o, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o, o_dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%h/%b expected all zero",
                     init_done_o, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o, o_dbg_state);
        end
        rst_i = 1'b0;
        count_init_edges("init_after_reset");
        n_cmp++;
        if (o_dbg_state !== 1'b1) begin
            n_err++;
            $display("FAIL state_ready: got %b expected 1", o_dbg_state);
        end
    endtask

    task automatic test_all_zero(input string name);
        logic v, pv;
        logic [DW-1:0] p;
        for (int a = 0; a < 16; a++) begin
            read_entry(a, v, pv, p);
            n_cmp++;
            if ({v, pv, p} !== {1'b1, 1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL %s[%0d]: got v=%b val=%b ptr=%h expected v=1 val=0 ptr=00", name, a, v, pv, p);
            end
        end
    endtask

    task automatic test_write_read();
        write_entry(5, 8'h2A, 1'b1);
        rd_addr_i = 4'd5;
        rd_en_i   = 1'b1;
        tick();
        rd_en_i   = 1'b0;
        n_cmp++;
        if (rd_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL wr_rd_early0: rd_valid got %b expected 0", rd_valid_o);
        end
        tick();
        n_cmp++;
        if (rd_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL wr_rd_early1: rd_valid got %b expected 0", rd_valid_o);
        end
        tick();
        n_cmp++;
        if ({rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o} !== {1'b1, 1'b1, 8'h2A}) begin
            n_err++;
            $display("FAIL wr_rd_data: got v=%b val=%b ptr=%h expected v=1 val=1 ptr=2a",
                     rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o);
        end
        tick();
        n_cmp++;
        if ({rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o} !== {1'b0, 1'b1, 8'h2A}) begin
            n_err++;
            $display("FAIL wr_rd_hold: got v=%b val=%b ptr=%h expected v=0 val=1 ptr=2a",
                     rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o);
        end
    endtask

    task automatic test_bypass();
        logic v, pv;
        logic [DW-1:0] p;
        wr_addr_i = 4'd3; wr_data_ptr_i = 8'h11; wr_data_ptr_val_i = 1'b1; wr_en_i = 1'b1;
        rd_addr_i = 4'd3; rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        wr_data_ptr_i = 8'h22;
        tick();
        wr_en_i = 1'b0;
        tick();
        n_cmp++;
        if ({rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o} !== {1'b1, 1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL bypass_same_edge: got v=%b val=%b ptr=%h expected v=1 val=1 ptr=11",
                     rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o);
        end
        read_entry(3, v, pv, p);
        n_cmp++;
        if ({v, pv, p} !== {1'b1, 1'b1, 8'h22}) begin
            n_err++;
            $display("FAIL later_write: got v=%b val=%b ptr=%h expected v=1 val=1 ptr=22", v, pv, p);
        end
        // same-edge write to a different address must not be forwarded
        wr_addr_i = 4'd4; wr_data_ptr_i = 8'h33; wr_data_ptr_val_i = 1'b1; wr_en_i = 1'b1;
        read_entry(3, v, pv, p);
        wr_en_i = 1'b0;
        n_cmp++;
        if ({v, pv, p} !== {1'b1, 1'b1, 8'h22}) begin
            n_err++;
            $display("FAIL bypass_other_addr: got v=%b val=%b ptr=%h expected v=1 val=1 ptr=22", v, pv, p);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) begin
            exp_ptr[a] = 8'(a * 19 + 7);
            exp_val[a] = a[0];
            write_entry(a, exp_ptr[a], exp_val[a]);
        end
        for (int c = 0; c < 20; c++) begin
            rd_en_i   = (c < 16);
            rd_addr_i = 4'(c);
            tick();
            n_cmp++;
            if (c >= 2 && c < 18) begin
                if ({rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o} !== {1'b1, exp_val[c-2], exp_ptr[c-2]}) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: got v=%b val=%b ptr=%h expected v=1 val=%b ptr=%h",
                             c - 2, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o, exp_val[c-2], exp_ptr[c-2]);
                end
            end else if (rd_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_idle[%0d]: rd_valid got %b expected 0", c, rd_valid_o);
            end
        end
        rd_en_i = 1'b0;
    endtask

    task automatic test_clear();
        int low_cnt;
        clear_i = 1'b1;
        wr_addr_i = 4'd7; wr_data_ptr_i = 8'hEE; wr_data_ptr_val_i = 1'b1; wr_en_i = 1'b1;
        rd_addr_i = 4'd7; rd_en_i = 1'b1;
        tick();
        clear_i = 1'b0;
        wr_addr_i = 4'd2; wr_data_ptr_i = 8'h77; rd_addr_i = 4'd2;
        low_cnt = init_done_o ? 0 : 1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            n_cmp++;
            if (j == 2) begin
                if ({rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o} !== {1'b1, exp_val[7], exp_ptr[7]}) begin
                    n_err++;
                    $display("FAIL clear_inflight: got v=%b val=%b ptr=%h expected v=1 val=%b ptr=%h",
                             rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o, exp_val[7], exp_ptr[7]);
                end
            end else if (rd_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL init_read_ignored[%0d]: rd_valid got %b expected 0", j, rd_valid_o);
            end
            if (init_done_o) break;
            low_cnt++;
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        n_cmp++;
        if (low_cnt !== 16) begin
            n_err++;
            $display("FAIL clear_low_cycles: got %0d expected 16", low_cnt);
        end
        tick();
        tick();
        n_cmp++;
        if (rd_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL init_last_read: rd_valid got %b expected 0", rd_valid_o);
        end
        test_all_zero("after_clear");
    endtask

    task automatic test_reset_mid();
        logic v, pv;
        logic [DW-1:0] p;
        write_entry(6, 8'h5C, 1'b1);
        read_entry(6, v, pv, p);
        n_cmp++;
        if ({v, pv, p} !== {1'b1, 1'b1, 8'h5C}) begin
            n_err++;
            $display("FAIL pre_reset_read: got v=%b val=%b ptr=%h expected v=1 val=1 ptr=5c", v, pv, p);
        end
        rd_addr_i = 4'd6;
        rd_en_i   = 1'b1;
        tick();
        rd_en_i   = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({init_done_o, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o} !== '0) begin
            n_err++;
            $display("FAIL rst_read_async: got %b/%b/%b/%h expected all zero",
                     init_done_o, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (rd_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_pulse[%0d]: rd_valid got %b expected 0", k, rd_valid_o);
            end
        end
        rst_i = 1'b0;
        repeat (7) tick();
        n_cmp++;
        if ({init_done_o, o_dbg_state} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_init_state: got done=%b state=%b expected 0/0", init_done_o, o_dbg_state);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({init_done_o, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o, o_dbg_state} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_init: got %b/%b/%b/%h/%b expected all zero",
                     init_done_o, rd_valid_o, rd_data_ptr_val_o, rd_data_ptr_o, o_dbg_state);
        end
        tick();
        rst_i = 1'b0;
        count_init_edges("init_rerun");
        read_entry(6, v, pv, p);
        n_cmp++;
        if ({v, pv, p} !== {1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL rerun_cleared: got v=%b val=%b ptr=%h expected v=1 val=0 ptr=00", v, pv, p);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero("init_zero");
        test_write_read();
        test_bypass();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000 ns");
        $fatal(1);
    end

endmodule
